sq_fwd_multiport: RTL and testbench
===================================

# sq_fwd_multiport

Parametrised store queue for the out-of-order memory path: accepts up to DISPATCH_WIDTH stores per cycle, captures address/data from the address-generation FU, and serves NUM_LD_PORTS concurrent store-to-load forwarding queries with age ordering and byte masks. Committed stores drain in order to the D-cache store port with a valid/accept handshake. Branch recovery rolls the tail back to a checkpointed pointer. Replaces the single-dispatch, single-query SQ inside the LSQ top level.

## Interface
- SQ_SIZE, 16: entries; power of two, ≥4
- DISPATCH_WIDTH, 2: enqueue lanes per cycle
- NUM_LD_PORTS, 2: independent forwarding query channels
- PTR_W, $clog2(SQ_SIZE)+1: age pointer width (index plus wrap bit)

- clock  in  1  system clock; reset reset, asynchronous, active-high; clock clock
- reset  in  1  asynchronous, active-high
- enq_valid  in  [DISPATCH_WIDTH]  per-lane store dispatch; valid lanes contiguous from lane 0
- enq_rob_idx  in  [DISPATCH_WIDTH] x ROB_IDX  owning ROB entry
- enq_size  in  [DISPATCH_WIDTH] x MEM_SIZE  BYTE/HALF/WORD
- free_cnt  out  $clog2(SQ_SIZE+1)  free entries
- tail_o  out  PTR_W  current tail; dispatch tags each load with it
- empty  out  1  no live entries
- exe_valid  in  1  address/data result from FU
- exe_rob_idx  in  ROB_IDX  matched against live entries
- exe_addr  in  32  byte address
- exe_data  in  32  store data, right-aligned
- ld_q_valid  in  [NUM_LD_PORTS]  forwarding query
- ld_q_addr  in  [NUM_LD_PORTS] x 32  load address
- ld_q_size  in  [NUM_LD_PORTS] x MEM_SIZE  load size
- ld_q_tag  in  [NUM_LD_PORTS] x PTR_W  SQ tail at load dispatch (stores before it are older)
- ld_fwd_hit  out  [NUM_LD_PORTS]  full-coverage forward available
- ld_fwd_data  out  [NUM_LD_PORTS] x 32  forwarded bytes, aligned to load
- ld_fwd_stall  out  [NUM_LD_PORTS]  load must retry
- commit_valid  in  1  ROB retiring a store
- commit_rob_idx  in  ROB_IDX  retiring store
- dc_req_valid  out  1  head store ready
- dc_req_addr  out  32;  dc_req_size  out  MEM_SIZE;  dc_req_data  out  32
- dc_req_accept  in  1  cache took the request
- flush_valid  in  1  mispredict recovery
- flush_tail  in  PTR_W  checkpointed tail to restore

## Operation
- Entry fields: valid, rob_idx, size, addr_valid, addr, data_valid, data, committed.
- Enqueue: lane i writes entry tail+i; tail advances by popcount(enq_valid). Dispatch guarantees popcount ≤ free_cnt; overflow is a simulation assertion, lanes beyond free_cnt are dropped.
- exe_valid: CAM on rob_idx over valid entries; sets addr, data, addr_valid, data_valid. No match → ignored.
- commit: CAM on rob_idx sets committed. Commit on entry without addr/data valid is an assertion.
- Drain: dc_req_valid = head.valid & committed & addr_valid & data_valid. On dc_req_valid & dc_req_accept, head clears and advances.
- Byte mask: BYTE → 1<<addr[1:0]; HALF → 2'b11<<{addr[1],1'b0}; WORD → 4'hF; misaligned accesses unsupported.
- Forward, per port: candidates = valid entries in [head, ld_q_tag). Youngest candidate with addr_valid, same word address and mask overlap is the match.
  - match mask ⊇ load mask and data_valid → hit=1, data shifted to load alignment.
  - match partial or data not valid → stall=1.
  - Any older candidate with addr_valid=0 → stall=1 (see Configuration).
  - No match, no unknown → hit=0, stall=0 (load goes to cache). hit and stall never both 1.
- Flush: tail ← flush_tail; entries in [flush_tail, old tail) cleared. Committed entries never lie in that range (ROB guarantee). free_cnt recomputed from pointers.
- Wrap: full when tail−head = SQ_SIZE with differing wrap bits; empty when equal.

## Timing
- Reset: head=tail=0, all valid=0; free_cnt=SQ_SIZE, empty=1, tail_o=0, dc_req_valid=0, ld_fwd_hit/stall/data=0.
- Enqueue, exe update, commit, dequeue take effect at the next posedge; forwarding outputs combinational from registered state plus query inputs (0-cycle).
- exe data is not forwarded in the cycle it arrives; visible the next cycle.
- Commit and drain of the same entry same cycle: dc_req_valid rises the cycle after commit.
- Simultaneous: enqueue + dequeue both apply; flush overrides enqueue (same-cycle enq ignored) but dequeue still applies; exe_valid on a flushed entry is dropped.
- Reset mid-operation clears all state asynchronously; an outstanding dc_req is abandoned.

## Configuration
- SQ_SPEC_LOAD_EN defined: older stores with unknown address are ignored in forwarding (speculative load bypass; ordering violation detection is the LQ's job). Undefined: any older unknown-address store forces ld_fwd_stall.

## Structure
- lsq_pkg: sq_entry_t, SQ_PTR typedef, size_to_mask function, byte-align helper.
- Sub-module sq_fwd_match: one instance per load port; takes entry array, head, query → hit/stall/data.

## Test plan
- Dispatch 2 stores (rob 3,4) in one cycle → free_cnt 16→14, tail_o=2 next cycle.
- Store WORD 0x100=0xDEADBEEF, load BYTE 0x102 tag after it → hit=1, data=0x000000AD.
- Store BYTE 0x100, load WORD 0x100 → stall=1; older store addr unknown → stall=1 without SQ_SPEC_LOAD_EN, hit=0/stall=0 with it.
- Two ports query same cycle, one older-only, one younger-tagged → each sees only its older stores.
- Commit head, hold dc_req_accept=0 three cycles → dc_req_valid held stable, dequeue on accept.
- Fill 16, flush_tail=10 with head=0 → free_cnt=6; refill wraps to index 0 correctly.

Source files
------------

// File: rtl/sq_fwd_multiport_pkg.sv
// Shared types and helpers for the multi-port store queue: entry layout,
// access sizes, byte-mask generation and forward-data alignment.
package sq_fwd_multiport_pkg;

  localparam int ROB_IDX_W = 6;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    mem_size_e            size;
    logic                 addr_valid;
    logic [31:0]          addr;
    logic                 data_valid;
    logic [31:0]          data;
    logic                 committed;
  } sq_entry_t;

  function automatic logic [3:0] size_to_mask(mem_size_e sz, logic [1:0] off);
    case (sz)
      MEM_BYTE: size_to_mask = 4'b0001 << off;
      MEM_HALF: size_to_mask = 4'b0011 << {off[1], 1'b0};
      default:  size_to_mask = 4'hF;
    endcase
  endfunction

  // Store data is right-aligned; place it in its word lane, then pull out the load's lane.
  function automatic logic [31:0] fwd_align(logic [31:0] st_data, logic [1:0] st_off,
                                            logic [1:0] ld_off, mem_size_e ld_size);
    logic [31:0] w_word;
    logic [31:0] w_out;
    w_word = st_data << {st_off, 3'b000};
    w_out  = w_word >> {ld_off, 3'b000};
    case (ld_size)
      MEM_BYTE: fwd_align = {24'h0, w_out[7:0]};
      MEM_HALF: fwd_align = {16'h0, w_out[15:0]};
      default:  fwd_align = w_out;
    endcase
  endfunction

endpackage

// File: rtl/sq_fwd_multiport_if.sv
// Store-queue bus: dispatch, execute, forwarding query, commit, D-cache drain, flush.
interface sq_fwd_multiport_if #(
  parameter int SQ_SIZE        = 16,
  parameter int DISPATCH_WIDTH = 2,
  parameter int NUM_LD_PORTS   = 2,
  parameter int PTR_W          = $clog2(SQ_SIZE) + 1,
  parameter int FREE_W         = $clog2(SQ_SIZE + 1)
) ();
  import sq_fwd_multiport_pkg::*;

  logic [DISPATCH_WIDTH-1:0]                enq_valid;
  logic [DISPATCH_WIDTH-1:0][ROB_IDX_W-1:0] enq_rob_idx;
  mem_size_e [DISPATCH_WIDTH-1:0]           enq_size;
  logic [FREE_W-1:0]                        free_cnt;
  logic [PTR_W-1:0]                         tail_o;
  logic                                     empty;

  logic                 exe_valid;
  logic [ROB_IDX_W-1:0] exe_rob_idx;
  logic [31:0]          exe_addr;
  logic [31:0]          exe_data;

  logic [NUM_LD_PORTS-1:0]             ld_q_valid;
  logic [NUM_LD_PORTS-1:0][31:0]       ld_q_addr;
  mem_size_e [NUM_LD_PORTS-1:0]        ld_q_size;
  logic [NUM_LD_PORTS-1:0][PTR_W-1:0]  ld_q_tag;
  logic [NUM_LD_PORTS-1:0]             ld_fwd_hit;
  logic [NUM_LD_PORTS-1:0][31:0]       ld_fwd_data;
  logic [NUM_LD_PORTS-1:0]             ld_fwd_stall;

  logic                 commit_valid;
  logic [ROB_IDX_W-1:0] commit_rob_idx;

  logic        dc_req_valid;
  logic [31:0] dc_req_addr;
  mem_size_e   dc_req_size;
  logic [31:0] dc_req_data;
  logic        dc_req_accept;

  logic             flush_valid;
  logic [PTR_W-1:0] flush_tail;

  modport master (
    output enq_valid, enq_rob_idx, enq_size, exe_valid, exe_rob_idx, exe_addr, exe_data,
           ld_q_valid, ld_q_addr, ld_q_size, ld_q_tag, commit_valid, commit_rob_idx,
           dc_req_accept, flush_valid, flush_tail,
    input  free_cnt, tail_o, empty, ld_fwd_hit, ld_fwd_data, ld_fwd_stall,
           dc_req_valid, dc_req_addr, dc_req_size, dc_req_data
  );

  modport slave (
    input  enq_valid, enq_rob_idx, enq_size, exe_valid, exe_rob_idx, exe_addr, exe_data,
           ld_q_valid, ld_q_addr, ld_q_size, ld_q_tag, commit_valid, commit_rob_idx,
           dc_req_accept, flush_valid, flush_tail,
    output free_cnt, tail_o, empty, ld_fwd_hit, ld_fwd_data, ld_fwd_stall,
           dc_req_valid, dc_req_addr, dc_req_size, dc_req_data
  );
endinterface

// File: rtl/sq_fwd_multiport_match.sv
// Per-load-port forwarding search over the store queue (combinational).
// SQ_SPEC_LOAD_EN: older stores with unknown address do not force a stall.
module sq_fwd_match
  import sq_fwd_multiport_pkg::*;
#(
  parameter int SQ_SIZE = 16,
  parameter int PTR_W   = $clog2(SQ_SIZE) + 1
) (
  input  sq_entry_t        i_entries [SQ_SIZE],
  input  logic [PTR_W-1:0] i_head,
  input  logic             i_q_valid,
  input  logic [31:0]      i_q_addr,
  input  mem_size_e        i_q_size,
  input  logic [PTR_W-1:0] i_q_tag,
  output logic             o_hit,
  output logic             o_stall,
  output logic [31:0]      o_data
);
  localparam int IDX_W = $clog2(SQ_SIZE);

  logic [PTR_W-1:0] w_span;
  logic [3:0]       w_ld_mask;
  logic [3:0]       w_st_mask;
  logic [3:0]       w_sel_mask;
  sq_entry_t        w_e;
  sq_entry_t        w_sel;
  logic             w_match;
  logic             w_unknown;
  logic             w_block;
  logic             w_cover;

  // Walk oldest to youngest so the last overlapping store seen is the youngest.
  always_comb begin
    w_span     = i_q_tag - i_head;
    w_ld_mask  = size_to_mask(i_q_size, i_q_addr[1:0]);
    w_e        = '0;
    w_st_mask  = '0;
    w_sel      = '0;
    w_sel_mask = '0;
    w_match    = 1'b0;
    w_unknown  = 1'b0;
    for (int k = 0; k < SQ_SIZE; k++) begin
      w_e       = i_entries[i_head[IDX_W-1:0] + IDX_W'(k)];
      w_st_mask = size_to_mask(w_e.size, w_e.addr[1:0]);
      if ((PTR_W'(k) < w_span) && w_e.valid) begin
        if (!w_e.addr_valid) begin
          w_unknown = 1'b1;
        end else if ((w_e.addr[31:2] == i_q_addr[31:2]) && |(w_st_mask & w_ld_mask)) begin
          w_match    = 1'b1;
          w_sel      = w_e;
          w_sel_mask = w_st_mask;
        end
      end
    end
  end

`ifdef SQ_SPEC_LOAD_EN
  assign w_block = 1'b0;
`else
  assign w_block = w_unknown;
`endif

  assign w_cover = &(w_sel_mask | ~w_ld_mask);
  assign o_hit   = i_q_valid && !w_block && w_match && w_cover && w_sel.data_valid;
  assign o_stall = i_q_valid && (w_block || (w_match && !(w_cover && w_sel.data_valid)));
  assign o_data  = o_hit ? fwd_align(w_sel.data, w_sel.addr[1:0], i_q_addr[1:0], i_q_size) : '0;

endmodule

// File: rtl/sq_fwd_multiport.sv
// Multi-dispatch store queue with per-port store-to-load forwarding, in-order
// D-cache drain and branch-recovery tail rollback. Build option: SQ_SPEC_LOAD_EN.
module sq_fwd_multiport
  import sq_fwd_multiport_pkg::*;
#(
  parameter int SQ_SIZE        = 16,
  parameter int DISPATCH_WIDTH = 2,
  parameter int NUM_LD_PORTS   = 2,
  parameter int PTR_W          = $clog2(SQ_SIZE) + 1
) (
  input logic               clock,
  input logic               reset,
  sq_fwd_multiport_if.slave sq
);
  localparam int IDX_W  = $clog2(SQ_SIZE);
  localparam int FREE_W = $clog2(SQ_SIZE + 1);

  sq_entry_t        r_entries [SQ_SIZE];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;

  logic [FREE_W-1:0] w_free;
  logic [PTR_W-1:0]  w_enq_cnt;
  logic [PTR_W-1:0]  w_fl_span;
  logic [IDX_W-1:0]  w_fl_off;
  logic [SQ_SIZE-1:0] w_in_flush;
  logic [DISPATCH_WIDTH-1:0] w_lane_en;
  logic [IDX_W-1:0]  w_lane_idx [DISPATCH_WIDTH];
  sq_entry_t         w_new [DISPATCH_WIDTH];
  sq_entry_t         w_head_e;
  logic              w_dc_valid;
  logic              w_deq;
  logic              w_commit_ok;

  assign w_free     = FREE_W'(SQ_SIZE) - FREE_W'(r_tail - r_head);
  assign w_head_e   = r_entries[r_head[IDX_W-1:0]];
  assign w_dc_valid = w_head_e.valid & w_head_e.committed & w_head_e.addr_valid & w_head_e.data_valid;
  assign w_deq      = w_dc_valid & sq.dc_req_accept;

  // Lanes past the free count are dropped; a flush cancels the whole dispatch group.
  always_comb begin
    w_enq_cnt = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      w_lane_en[i]      = sq.enq_valid[i] && (i < int'(w_free)) && !sq.flush_valid;
      w_lane_idx[i]     = r_tail[IDX_W-1:0] + IDX_W'(i);
      w_new[i]          = '0;
      w_new[i].valid    = 1'b1;
      w_new[i].rob_idx  = sq.enq_rob_idx[i];
      w_new[i].size     = sq.enq_size[i];
      if (w_lane_en[i]) w_enq_cnt = w_enq_cnt + PTR_W'(1);
    end
  end

  always_comb begin
    w_fl_span   = r_tail - sq.flush_tail;
    w_fl_off    = '0;
    w_commit_ok = 1'b1;
    for (int j = 0; j < SQ_SIZE; j++) begin
      w_fl_off      = IDX_W'(j) - sq.flush_tail[IDX_W-1:0];
      w_in_flush[j] = PTR_W'(w_fl_off) < w_fl_span;
      if (sq.commit_valid && r_entries[j].valid && (r_entries[j].rob_idx == sq.commit_rob_idx)
          && !(r_entries[j].addr_valid && r_entries[j].data_valid))
        w_commit_ok = 1'b0;
    end
  end

  // Later assignments win: flush beats exe/commit, dequeue clears the head last.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < SQ_SIZE; j++) r_entries[j] <= '0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      for (int j = 0; j < SQ_SIZE; j++) begin
        if (sq.exe_valid && r_entries[j].valid && (r_entries[j].rob_idx == sq.exe_rob_idx)) begin
          r_entries[j].addr       <= sq.exe_addr;
          r_entries[j].data       <= sq.exe_data;
          r_entries[j].addr_valid <= 1'b1;
          r_entries[j].data_valid <= 1'b1;
        end
        if (sq.commit_valid && r_entries[j].valid && (r_entries[j].rob_idx == sq.commit_rob_idx))
          r_entries[j].committed <= 1'b1;
        if (sq.flush_valid && w_in_flush[j])
          r_entries[j] <= '0;
      end
      for (int i = 0; i < DISPATCH_WIDTH; i++)
        if (w_lane_en[i]) r_entries[w_lane_idx[i]] <= w_new[i];
      if (w_deq) begin
        r_entries[r_head[IDX_W-1:0]] <= '0;
        r_head <= r_head + PTR_W'(1);
      end
      r_tail <= sq.flush_valid ? sq.flush_tail : (r_tail + w_enq_cnt);
    end
  end

  logic [NUM_LD_PORTS-1:0]        w_hit;
  logic [NUM_LD_PORTS-1:0]        w_stall;
  logic [NUM_LD_PORTS-1:0][31:0]  w_data;

  for (genvar p = 0; p < NUM_LD_PORTS; p++) begin : g_port
    sq_fwd_match #(.SQ_SIZE(SQ_SIZE), .PTR_W(PTR_W)) u_match (
      .i_entries (r_entries),
      .i_head    (r_head),
      .i_q_valid (sq.ld_q_valid[p]),
      .i_q_addr  (sq.ld_q_addr[p]),
      .i_q_size  (sq.ld_q_size[p]),
      .i_q_tag   (sq.ld_q_tag[p]),
      .o_hit     (w_hit[p]),
      .o_stall   (w_stall[p]),
      .o_data    (w_data[p])
    );
  end

  assign sq.ld_fwd_hit   = w_hit;
  assign sq.ld_fwd_stall = w_stall;
  assign sq.ld_fwd_data  = w_data;
  assign sq.free_cnt     = w_free;
  assign sq.tail_o       = r_tail;
  assign sq.empty        = (r_head == r_tail);
  assign sq.dc_req_valid = w_dc_valid;
  assign sq.dc_req_addr  = w_head_e.addr;
  assign sq.dc_req_size  = w_head_e.size;
  assign sq.dc_req_data  = w_head_e.data;

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    sq.flush_valid || ($countones(sq.enq_valid) <= int'(w_free)));
  a_commit_ready: assert property (@(posedge clock) disable iff (reset) w_commit_ok);

endmodule

// File: tb/tb_sq_fwd_multiport.sv
// Scoreboard bench for sq_fwd_multiport: directed stimulus pushes expectations,
// a negedge monitor pops and compares whatever the queue presents.
`timescale 1ns/1ps
module tb_sq_fwd_multiport;
  import sq_fwd_multiport_pkg::*;

  localparam int SQ_SIZE = 16;
  localparam int DW      = 2;
  localparam int NP      = 2;
  localparam int PTR_W   = 5;
  localparam int FREE_W  = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sq_fwd_multiport_if #(.SQ_SIZE(SQ_SIZE), .DISPATCH_WIDTH(DW), .NUM_LD_PORTS(NP)) sq ();

  sq_fwd_multiport #(.SQ_SIZE(SQ_SIZE), .DISPATCH_WIDTH(DW), .NUM_LD_PORTS(NP)) dut (
    .clock (clock),
    .reset (reset),
    .sq    (sq)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic chk_stat = 1'b0;
  logic [11:0] stat_q[$];
  logic [33:0] fwd_q0[$];
  logic [33:0] fwd_q1[$];
  logic [65:0] dc_q[$];

  task automatic check(string nm, logic [65:0] act, logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic no_exp(string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: DUT output seen with no expected entry queued", nm);
  endtask

  // Monitor: sampled on the falling edge, away from input changes and clock edges.
  always @(negedge clock) begin
    if (chk_stat) begin
      if (stat_q.size() == 0) no_exp("status");
      else check("status", 66'({sq.free_cnt, sq.tail_o, sq.empty, sq.dc_req_valid}), 66'(stat_q.pop_front()));
    end
    if (sq.ld_q_valid[0]) begin
      if (fwd_q0.size() == 0) no_exp("fwd_p0");
      else check("fwd_p0", 66'({sq.ld_fwd_hit[0], sq.ld_fwd_stall[0], sq.ld_fwd_data[0]}), 66'(fwd_q0.pop_front()));
    end
    if (sq.ld_q_valid[1]) begin
      if (fwd_q1.size() == 0) no_exp("fwd_p1");
      else check("fwd_p1", 66'({sq.ld_fwd_hit[1], sq.ld_fwd_stall[1], sq.ld_fwd_data[1]}), 66'(fwd_q1.pop_front()));
    end
    if (sq.dc_req_valid) begin
      if (dc_q.size() == 0) no_exp("dc_req");
      else begin
        check("dc_req", {sq.dc_req_addr, 2'(sq.dc_req_size), sq.dc_req_data}, dc_q[0]);
        if (sq.dc_req_accept) void'(dc_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
    sq.enq_valid    = '0;
    sq.exe_valid    = 1'b0;
    sq.commit_valid = 1'b0;
    sq.flush_valid  = 1'b0;
    sq.ld_q_valid   = '0;
    chk_stat        = 1'b0;
  endtask

  task automatic exp_stat(int f, int t, bit e, bit v);
    stat_q.push_back({FREE_W'(f), PTR_W'(t), e, v});
    chk_stat = 1'b1;
  endtask

  task automatic enq(int lane, int rob, mem_size_e sz);
    sq.enq_valid[lane]   = 1'b1;
    sq.enq_rob_idx[lane] = ROB_IDX_W'(rob);
    sq.enq_size[lane]    = sz;
  endtask

  task automatic exe(int rob, logic [31:0] addr, logic [31:0] data);
    sq.exe_valid   = 1'b1;
    sq.exe_rob_idx = ROB_IDX_W'(rob);
    sq.exe_addr    = addr;
    sq.exe_data    = data;
  endtask

  task automatic commit(int rob);
    sq.commit_valid   = 1'b1;
    sq.commit_rob_idx = ROB_IDX_W'(rob);
  endtask

  task automatic query(int p, logic [31:0] addr, mem_size_e sz, int tag,
                       bit hit, bit stall, logic [31:0] data);
    sq.ld_q_valid[p] = 1'b1;
    sq.ld_q_addr[p]  = addr;
    sq.ld_q_size[p]  = sz;
    sq.ld_q_tag[p]   = PTR_W'(tag);
    if (p == 0) fwd_q0.push_back({hit, stall, data});
    else        fwd_q1.push_back({hit, stall, data});
  endtask

  task automatic expect_dc(logic [31:0] addr, mem_size_e sz, logic [31:0] data);
    dc_q.push_back({addr, 2'(sz), data});
  endtask

  initial begin
    sq.enq_valid = '0; sq.enq_rob_idx = '0; sq.enq_size = '{default: MEM_BYTE};
    sq.exe_valid = 1'b0; sq.exe_rob_idx = '0; sq.exe_addr = '0; sq.exe_data = '0;
    sq.ld_q_valid = '0; sq.ld_q_addr = '0; sq.ld_q_size = '{default: MEM_BYTE}; sq.ld_q_tag = '0;
    sq.commit_valid = 1'b0; sq.commit_rob_idx = '0;
    sq.dc_req_accept = 1'b0; sq.flush_valid = 1'b0; sq.flush_tail = '0;

    @(posedge clock); #1;
    exp_stat(16, 0, 1'b1, 1'b0);
    query(0, 32'h100, MEM_WORD, 0, 1'b0, 1'b0, 32'h0);
    cyc(); reset = 1'b0;
    exp_stat(16, 0, 1'b1, 1'b0);

    // Two-lane dispatch: rob 3 WORD, rob 4 BYTE
    cyc(); enq(0, 3, MEM_WORD); enq(1, 4, MEM_BYTE); exp_stat(16, 0, 1'b1, 1'b0);
    cyc(); exp_stat(14, 2, 1'b0, 1'b0); exe(3, 32'h100, 32'hDEADBEEF);
`ifdef SQ_SPEC_LOAD_EN
    query(0, 32'h102, MEM_BYTE, 2, 1'b0, 1'b0, 32'h0);
`else
    query(0, 32'h102, MEM_BYTE, 2, 1'b0, 1'b1, 32'h0);
`endif
    cyc(); exe(4, 32'h100, 32'h00000055);
    query(0, 32'h102, MEM_BYTE, 1, 1'b1, 1'b0, 32'h000000AD);
`ifdef SQ_SPEC_LOAD_EN
    query(1, 32'h102, MEM_BYTE, 2, 1'b1, 1'b0, 32'h000000AD);
`else
    query(1, 32'h102, MEM_BYTE, 2, 1'b0, 1'b1, 32'h0);
`endif
    cyc();
    query(0, 32'h100, MEM_WORD, 2, 1'b0, 1'b1, 32'h0);
    query(1, 32'h100, MEM_BYTE, 2, 1'b1, 1'b0, 32'h00000055);
    cyc();
    query(0, 32'h103, MEM_BYTE, 2, 1'b1, 1'b0, 32'h000000DE);
    query(1, 32'h102, MEM_HALF, 2, 1'b1, 1'b0, 32'h0000DEAD);
    cyc();
    query(0, 32'h100, MEM_HALF, 2, 1'b0, 1'b1, 32'h0);
    query(1, 32'h104, MEM_WORD, 2, 1'b0, 1'b0, 32'h0);

    // Drain with back-pressure: request must hold for three refused cycles
    cyc(); commit(3); expect_dc(32'h100, MEM_WORD, 32'hDEADBEEF); exp_stat(14, 2, 1'b0, 1'b0);
    cyc(); cyc(); cyc();
    cyc(); sq.dc_req_accept = 1'b1;
    cyc(); sq.dc_req_accept = 1'b0; exp_stat(15, 2, 1'b0, 1'b0);
    commit(4); expect_dc(32'h100, MEM_BYTE, 32'h00000055);
    cyc(); sq.dc_req_accept = 1'b1;
    cyc(); sq.dc_req_accept = 1'b0; exp_stat(16, 2, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a cycle
    cyc(); enq(0, 7, MEM_WORD); enq(1, 8, MEM_WORD);
    cyc(); exp_stat(14, 4, 1'b0, 1'b0);
    cyc(); #2 reset = 1'b1; exp_stat(16, 0, 1'b1, 1'b0);
    cyc(); reset = 1'b0;

    // Fill all 16 entries (entry k owns rob 20+k)
    for (int c = 0; c < 8; c++) begin
      cyc(); enq(0, 20 + 2 * c, MEM_WORD); enq(1, 21 + 2 * c, MEM_WORD);
    end
    cyc(); exp_stat(0, 16, 1'b0, 1'b0);
    sq.flush_valid = 1'b1; sq.flush_tail = PTR_W'(10);
    enq(0, 60, MEM_WORD); enq(1, 61, MEM_WORD);
    cyc(); exp_stat(6, 10, 1'b0, 1'b0);

    // Refill 10..15 with rob 40..45, then resolve every address
    for (int c = 0; c < 3; c++) begin
      cyc(); enq(0, 40 + 2 * c, MEM_WORD); enq(1, 41 + 2 * c, MEM_WORD);
    end
    cyc(); exp_stat(0, 16, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      exe((k < 10) ? (20 + k) : (30 + k), 32'h400 + 32'(4 * k), 32'(k));
      cyc();
    end
    query(0, 32'h404, MEM_WORD, 16, 1'b1, 1'b0, 32'h1);
    commit(20); expect_dc(32'h400, MEM_WORD, 32'h0); sq.dc_req_accept = 1'b1;
    cyc(); sq.dc_req_accept = 1'b1;
    cyc(); sq.dc_req_accept = 1'b0; exp_stat(1, 16, 1'b0, 1'b0); enq(0, 50, MEM_WORD);

    // New store lands in physical slot 0 but is the youngest entry
    cyc(); exp_stat(0, 17, 1'b0, 1'b0); exe(50, 32'h404, 32'hCAFEF00D);
`ifdef SQ_SPEC_LOAD_EN
    query(0, 32'h404, MEM_WORD, 17, 1'b1, 1'b0, 32'h1);
`else
    query(0, 32'h404, MEM_WORD, 17, 1'b0, 1'b1, 32'h0);
`endif
    cyc();
    query(0, 32'h404, MEM_WORD, 17, 1'b1, 1'b0, 32'hCAFEF00D);
    query(1, 32'h404, MEM_WORD, 16, 1'b1, 1'b0, 32'h1);
    cyc();
    query(0, 32'h406, MEM_HALF, 17, 1'b1, 1'b0, 32'h0000CAFE);
    repeat (3) cyc();

    check("stat_q_left", 66'(stat_q.size()), 66'd0);
    check("fwd_q0_left", 66'(fwd_q0.size()), 66'd0);
    check("fwd_q1_left", 66'(fwd_q1.size()), 66'd0);
    check("dc_q_left",   66'(dc_q.size()),   66'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
